// File: rtl/fcpu_pkg.sv
// Shared core widths for the result broadcast path: reservation-station tag,
// data word, and the combined common-data-bus beat layout {tag, data}.
package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    // One broadcast beat; tag occupies the bits above the data word.
    typedef struct packed {
        logic [RSV_ID_W-1:0] tag;
        logic [DATA_W-1:0]   data;
    } cdb_beat_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer in front of the CDB arbiter.
// Ready is a registered flag so the producer never sees a same-cycle pop:
// a full buffer stays not-ready in the cycle it is popped and reopens one
// cycle later. Ready is held low while reset is asserted.
module cdb_src_fifo #(
    parameter int WIDTH   = 36,
    parameter int DEPTH_W = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0] CNT_ZERO  = (DEPTH_W + 1)'(0);
    localparam logic [DEPTH_W:0] CNT_ONE   = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE = DEPTH_W'(1);

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_r;
    logic [DEPTH_W-1:0] rd_ptr_r;
    logic [DEPTH_W:0]   count_r;
    logic [DEPTH_W:0]   count_nxt_s;
    logic               ready_r;
    logic               push_s;
    logic               pop_s;

    assign push_s     = push_valid & ready_r;
    assign pop_s      = pop & (count_r != CNT_ZERO);
    assign push_ready = ready_r;
    assign head_data  = mem_r[rd_ptr_r];
    assign not_empty  = (count_r != CNT_ZERO);

    // Next occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered ready; pointers wrap naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= DEPTH_W'(0);
            rd_ptr_r <= DEPTH_W'(0);
            count_r  <= CNT_ZERO;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < DEPTH_CNT);
        end
    end

    // Storage array; contents are don't-care while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one buffer per functional-unit result source,
// a round-robin pick among non-empty buffers each cycle, and a registered
// broadcast. The picked head is popped on the same edge that loads cdb.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_SOURCES    = 4,
    parameter int FIFO_DEPTH_W = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [N_SOURCES-1:0]       src_valid,
    input  logic [N_SOURCES*CDB_W-1:0] src_data,
    output logic [N_SOURCES-1:0]       src_ready,
    output logic                       cdb_valid,
    output logic [CDB_W-1:0]           cdb
);

    localparam int IDX_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SOURCES - 1);

    logic [CDB_W-1:0]     head_data_s [N_SOURCES];
    logic [N_SOURCES-1:0] not_empty_s;
    logic [N_SOURCES-1:0] pop_s;
    logic                 grant_valid_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [IDX_W-1:0]     last_grant_r;
    logic                 cdb_valid_r;
    cdb_beat_t            cdb_r;

    for (genvar i = 0; i < N_SOURCES; i++) begin : g_src
        cdb_src_fifo #(
            .WIDTH   (CDB_W),
            .DEPTH_W (FIFO_DEPTH_W)
        ) u_fifo (
            .clk        (clk),
            .nrst       (nrst),
            .push_valid (src_valid[i]),
            .push_data  (src_data[i*CDB_W +: CDB_W]),
            .push_ready (src_ready[i]),
            .pop        (pop_s[i]),
            .head_data  (head_data_s[i]),
            .not_empty  (not_empty_s[i])
        );
    end

    // Round-robin pick: scan from farthest to nearest after last_grant so
    // the nearest non-empty source overwrites any farther candidate.
    always_comb begin
        int sum;
        int cand;
        logic [IDX_W-1:0] cand_idx;
        sum           = 0;
        cand          = 0;
        cand_idx      = IDX_W'(0);
        grant_valid_s = 1'b0;
        grant_idx_s   = IDX_W'(0);
        for (int k = N_SOURCES; k >= 1; k--) begin
            sum           = int'(last_grant_r) + k;
            cand          = (sum >= N_SOURCES) ? (sum - N_SOURCES) : sum;
            cand_idx      = IDX_W'(cand);
            grant_idx_s   = not_empty_s[cand_idx] ? cand_idx : grant_idx_s;
            grant_valid_s = grant_valid_s | not_empty_s[cand_idx];
        end
    end

    // One-hot pop of the granted buffer.
    always_comb begin
        pop_s              = {N_SOURCES{1'b0}};
        pop_s[grant_idx_s] = grant_valid_s;
    end

    // Broadcast register and round-robin pointer; cdb holds when idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cdb_valid_r  <= 1'b0;
            cdb_r        <= '{tag: RSV_ID_W'(0), data: DATA_W'(0)};
            last_grant_r <= LAST_IDX;
        end else if (grant_valid_s) begin
            cdb_valid_r  <= 1'b1;
            cdb_r        <= head_data_s[grant_idx_s];
            last_grant_r <= grant_idx_s;
        end else begin
            cdb_valid_r  <= 1'b0;
        end
    end

    assign cdb_valid = cdb_valid_r;
    assign cdb       = cdb_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (4 sources, depth 2): reset values, a
// table of single-cycle vectors, and sequences for backpressure, fairness,
// mid-operation reset and same-cycle push/pop.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 1;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [N-1:0]         src_valid;
    logic [N*CDB_W-1:0]   src_data;
    logic [N-1:0]         src_ready;
    logic                 cdb_valid;
    logic [CDB_W-1:0]     cdb;

    int n_assert = 0;
    int n_fail   = 0;

    cdb_arbiter #(.N_SOURCES(N), .FIFO_DEPTH_W(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb       (cdb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat encoding: {tag, 8'hA5, source id, sequence number}.
    function automatic logic [CDB_W-1:0] mk(input int src, input logic [3:0] tag, input int seq);
        return {tag, 8'hA5, 8'(src), 16'(seq)};
    endfunction

    // Behavioural reference: per-source queues of depth 2 and round robin.
    logic [CDB_W-1:0] m_buf [N][2];
    int               m_cnt [N];
    int               m_last;
    logic [N-1:0]     m_ready;
    logic             m_cv;
    logic [CDB_W-1:0] m_cdb;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_last  = N - 1;
        m_ready = 4'b1111;
        m_cv    = 1'b0;
        m_cdb   = 36'h0;
    endtask

    task automatic model_edge();
        logic [N-1:0] acc;
        int g;
        int c;
        acc = src_valid & m_ready;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (g < 0 && m_cnt[c] > 0) g = c;
        end
        if (g >= 0) begin
            m_cv        = 1'b1;
            m_cdb       = m_buf[g][0];
            m_buf[g][0] = m_buf[g][1];
            m_cnt[g]    = m_cnt[g] - 1;
            m_last      = g;
        end else begin
            m_cv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                m_buf[i][m_cnt[i]] = src_data[i*CDB_W +: CDB_W];
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        for (int i = 0; i < N; i++) m_ready[i] = (m_cnt[i] < 2);
    endtask

    task automatic step_model(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_cdb_valid"}, 64'(cdb_valid), 64'(m_cv));
        chk({tag, "_cdb"}, 64'(cdb), 64'(m_cdb));
        chk({tag, "_src_ready"}, 64'(src_ready), 64'(m_ready));
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst      = 1'b0;
        src_valid = 4'b0000;
        #2;
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] tag;
        logic [3:0] exp_ready;
        logic       exp_cv;
        int         exp_src;
        logic [3:0] exp_tag;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int sent1;
        logic [3:0] got [$];
        logic acc1;
        int sent [N];
        int win_cnt [N];
        int recv;
        int cyc;
        int s;
        logic [N-1:0] acc;

        // all sources, then contention order, push/pop on source 3, rotation
        tbl[0]  = '{4'b1111, 4'd1, 4'b1111, 1'b0, 0, 4'd0};
        tbl[1]  = '{4'b0000, 4'd0, 4'b1111, 1'b1, 0, 4'd1};
        tbl[2]  = '{4'b0000, 4'd0, 4'b1111, 1'b1, 1, 4'd1};
        tbl[3]  = '{4'b0000, 4'd0, 4'b1111, 1'b1, 2, 4'd1};
        tbl[4]  = '{4'b0000, 4'd0, 4'b1111, 1'b1, 3, 4'd1};
        tbl[5]  = '{4'b0000, 4'd0, 4'b1111, 1'b0, 0, 4'd0};
        tbl[6]  = '{4'b1000, 4'd2, 4'b1111, 1'b0, 0, 4'd0};
        tbl[7]  = '{4'b1000, 4'd3, 4'b1111, 1'b1, 3, 4'd2};
        tbl[8]  = '{4'b0000, 4'd0, 4'b1111, 1'b1, 3, 4'd3};
        tbl[9]  = '{4'b0000, 4'd0, 4'b1111, 1'b0, 0, 4'd0};
        tbl[10] = '{4'b0011, 4'd4, 4'b1111, 1'b0, 0, 4'd0};
        tbl[11] = '{4'b0000, 4'd0, 4'b1111, 1'b1, 0, 4'd4};
        tbl[12] = '{4'b0100, 4'd5, 4'b1111, 1'b1, 1, 4'd4};
        tbl[13] = '{4'b0000, 4'd0, 4'b1111, 1'b1, 2, 4'd5};
        tbl[14] = '{4'b0000, 4'd0, 4'b1111, 1'b0, 0, 4'd0};

        // ---- reset values ----
        nrst      = 1'b0;
        src_valid = 4'b0000;
        src_data  = '0;
        #3;
        chk("rst_ready", 64'(src_ready), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb", 64'(cdb), 64'h0);
        @(negedge clk);
        chk("rst_ready_held", 64'(src_ready), 64'h0);
        #2;
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_ready", 64'(src_ready), 64'hF);
        chk("rel_cdb_valid", 64'(cdb_valid), 64'h0);
        model_reset();

        // ---- single beat, two-cycle latency ----
        src_valid = 4'b0100;
        src_data[2*CDB_W +: CDB_W] = {4'd5, 32'hDEADBEEF};
        @(posedge clk);
        @(negedge clk);
        src_valid = 4'b0000;
        chk("single_early", 64'(cdb_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("single_valid", 64'(cdb_valid), 64'h1);
        chk("single_cdb", 64'(cdb), 64'h5DEADBEEF);
        @(posedge clk);
        @(negedge clk);
        chk("single_drop", 64'(cdb_valid), 64'h0);
        chk("single_hold", 64'(cdb), 64'h5DEADBEEF);

        // ---- table vectors ----
        do_reset();
        for (int k = 0; k < 15; k++) begin
            src_valid = tbl[k].valid;
            for (int i = 0; i < N; i++) src_data[i*CDB_W +: CDB_W] = mk(i, tbl[k].tag, 0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", k), 64'(src_ready), 64'(tbl[k].exp_ready));
            chk($sformatf("tbl%0d_cdb_valid", k), 64'(cdb_valid), 64'(tbl[k].exp_cv));
            if (tbl[k].exp_cv)
                chk($sformatf("tbl%0d_cdb", k), 64'(cdb), 64'(mk(tbl[k].exp_src, tbl[k].exp_tag, 0)));
        end

        // ---- source 1 streams tags 1..5, source 0 contends once ----
        do_reset();
        sent1 = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            src_valid = 4'b0000;
            src_valid[0] = (cyc == 0);
            src_data[0 +: CDB_W] = mk(0, 4'd9, 0);
            src_valid[1] = (sent1 < 5);
            src_data[CDB_W +: CDB_W] = mk(1, 4'(sent1 + 1), sent1);
            acc1 = src_valid[1] & src_ready[1];
            step_model("stream");
            if (acc1) sent1++;
            if (cyc == 1) chk("stream_ready1_full", 64'(src_ready[1]), 64'h0);
            if (cdb_valid && cdb[23:16] == 8'd1) got.push_back(cdb[35:32]);
        end
        chk("stream_count", 64'(got.size()), 64'd5);
        for (int k = 0; k < got.size() && k < 5; k++)
            chk($sformatf("stream_tag%0d", k), 64'(got[k]), 64'(k + 1));

        // ---- saturating load, 100 beats per source ----
        do_reset();
        recv = 0;
        cyc  = 0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            win_cnt[i] = 0;
        end
        while (recv < 400 && cyc < 700) begin
            for (int i = 0; i < N; i++) begin
                src_valid[i] = (sent[i] < 100);
                src_data[i*CDB_W +: CDB_W] = mk(i, 4'(sent[i] % 15), sent[i]);
            end
            acc = src_valid & src_ready;
            step_model("sat");
            for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
            if (cdb_valid) begin
                s = int'(cdb[23:16]);
                chk("sat_rr_order", 64'(s), 64'(recv % 4));
                if (recv < 100 && s < N) win_cnt[s]++;
                recv++;
            end
            cyc++;
        end
        chk("sat_total", 64'(recv), 64'd400);
        for (int i = 0; i < N; i++) chk($sformatf("sat_fair%0d", i), 64'(win_cnt[i]), 64'd25);

        // ---- reset while buffers are full ----
        do_reset();
        for (int c2 = 0; c2 < 6; c2++) begin
            src_valid = 4'b1111;
            for (int i = 0; i < N; i++) src_data[i*CDB_W +: CDB_W] = mk(i, 4'd15, 200 + c2);
            step_model("prefill");
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("midrst_cdb", 64'(cdb), 64'h0);
        chk("midrst_ready", 64'(src_ready), 64'h0);
        src_valid = 4'b0000;
        @(negedge clk);
        chk("midrst_held_valid", 64'(cdb_valid), 64'h0);
        #2;
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("midrst_rel_ready", 64'(src_ready), 64'hF);
        for (int c2 = 0; c2 < 6; c2++) step_model("postrst_idle");
        src_valid = 4'b0001;
        src_data[0 +: CDB_W] = mk(0, 4'd7, 1);
        step_model("postrst_push");
        src_valid = 4'b0000;
        step_model("postrst_bcast");
        chk("postrst_beat_valid", 64'(cdb_valid), 64'h1);
        chk("postrst_beat", 64'(cdb), 64'(mk(0, 4'd7, 1)));
        step_model("postrst_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The module SHALL have parameter N_SOURCES, default 4, giving the number of functional-unit result sources.
REQ-002 The module SHALL have parameter FIFO_DEPTH_W, default 1, giving per-source buffer depth 2**FIFO_DEPTH_W.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port src_valid  input  N_SOURCES  per-source result valid.
REQ-006 The module SHALL have port src_data  input  N_SOURCES*CDB_W  per-source result; slice i = {tag[RSV_ID_W], data[DATA_W]}, tag at bit offset DATA_W.
REQ-007 The module SHALL have port src_ready  output  N_SOURCES  per-source accept.
REQ-008 The module SHALL have port cdb_valid  output  1  broadcast valid.
REQ-009 The module SHALL have port cdb  output  CDB_W  broadcast {tag, data}, bit layout identical to src_data slices.

Function
REQ-010 A source beat SHALL transfer on a rising edge where src_valid[i] and src_ready[i] are both high.
REQ-011 src_ready[i] SHALL be high exactly when source i's buffer holds fewer than 2**FIFO_DEPTH_W entries, derived from registered state only, with no dependence on src_valid or on a same-cycle pop.
REQ-012 When a buffer is full, it SHALL deassert ready even in a cycle where it is being popped; ready returns the cycle after the pop.
REQ-013 Each buffer SHALL be FIFO per source; beats from one source SHALL broadcast in acceptance order.
REQ-014 Each cycle, the arbiter SHALL grant exactly one non-empty buffer, or none if all are empty.
REQ-015 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_SOURCES; last_grant updates only on a grant.
REQ-016 The granted head SHALL be popped on the same edge it is registered into cdb, with cdb_valid set to 1.
REQ-017 In a cycle with no grant, cdb_valid SHALL be 0 on the next edge and cdb SHALL hold its previous value.
REQ-018 Uncontended latency SHALL be 2 cycles: a beat accepted at edge E appears on cdb/cdb_valid after edge E+1.
REQ-019 There is no CDB backpressure: every registered cdb beat is valid for exactly one cycle.
REQ-020 Simultaneous push and pop on the same non-full buffer SHALL leave the occupancy unchanged and keep data in order.
REQ-021 Buffer read and write pointers SHALL wrap modulo 2**FIFO_DEPTH_W; occupancy SHALL use FIFO_DEPTH_W+1 bits.
REQ-022 Under continuous full load, each source SHALL be granted once every N_SOURCES cycles; no source starves.

Reset
REQ-023 When nrst is low, all buffers SHALL become empty asynchronously, with cdb_valid=0, cdb=0 and last_grant=N_SOURCES-1, so source 0 has first priority.
REQ-024 While nrst is low, src_ready SHALL be 0; after release it SHALL be all ones from the first edge.
REQ-025 Reset asserted mid-operation SHALL discard all buffered beats, and no partial beat SHALL appear on cdb.

Structure
REQ-026 RSV_ID_W, DATA_W and CDB_W (=RSV_ID_W+DATA_W) SHALL come from fcpu_pkg; no local redefinition is allowed.
REQ-027 The per-source buffer SHALL be sub-module cdb_src_fifo, parameterised by width CDB_W and FIFO_DEPTH_W, and instantiated N_SOURCES times.
REQ-028 The round-robin grant and the output register SHALL reside in cdb_arbiter itself.

Verification (N_SOURCES=4, FIFO_DEPTH_W=1, RSV_ID_W=4, DATA_W=32)
REQ-029 Single beat: source 2 sends tag 5, data 0xDEADBEEF at edge E -> cdb_valid=1 with cdb={5,0xDEADBEEF} after E+1 only, then cdb_valid=0.
REQ-030 All four sources push one beat at the same edge after reset -> broadcast order is source 0, 1, 2, 3 on four consecutive cycles.
REQ-031 Source 1 holds src_valid high for 5 beats (tags 1..5) while the others are idle -> src_ready[1] drops after 2 unpopped accepts, and cdb shows tags 1..5 in order with no loss or duplication.
REQ-032 Saturating load of 100 beats per source -> grant order repeats 0,1,2,3, and each source receives 25 grants per 100 cycles.
REQ-033 nrst pulsed low while all buffers are full -> cdb_valid=0 immediately, and no pre-reset tag is ever broadcast after release.
REQ-034 Push and pop on source 3 in the same cycle at occupancy 1 -> occupancy stays 1, src_ready[3] stays 1, and data order is preserved.
